// File: rtl/axi_stream_strip_header.sv
// AXI-Stream header stripper: drops S leading bytes, repacks beats.
// Define AXIS_STRIP_HEADER_CAPTURE_EN to expose the stripped header.
module axi_stream_strip_header #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
  parameter int BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [DATA_BYTE_WIDTH-1:0] keep_in,
  input  logic                       last_in,
  output logic                       ready_in,
  output logic                       valid_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [DATA_BYTE_WIDTH-1:0] keep_out,
  output logic                       last_out,
  input  logic                       ready_out,
  input  logic                       valid_strip,
  input  logic [BYTE_CNT_WIDTH-1:0]  byte_strip_cnt,
  output logic                       ready_strip
`ifdef AXIS_STRIP_HEADER_CAPTURE_EN
  ,
  output logic [DATA_WIDTH-1:0]      header_out,
  output logic                       header_valid
`endif
);

  localparam int DBW = DATA_BYTE_WIDTH;
  localparam int CW  = BYTE_CNT_WIDTH + 2;
  localparam int SW  = BYTE_CNT_WIDTH + 1;
  localparam logic [CW-1:0] DBW_C = CW'(DBW);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    STREAM,
    FLUSH
  } state_e;

  state_e                  state_q, state_d;
  logic [SW-1:0]           strip_q, strip_d;
  logic [DATA_WIDTH-1:0]   res_data_q, res_data_d;
  logic [CW-1:0]           res_cnt_q, res_cnt_d;
  logic                    vld_q, vld_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [DBW-1:0]          kep_q, kep_d;
  logic                    lst_q, lst_d;

  logic [CW-1:0]           k_in;
  logic [CW-1:0]           s_cnt;
  logic [CW-1:0]           tot;
  logic [DATA_WIDTH-1:0]   din_m;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    out_load;

  function automatic logic [DATA_WIDTH-1:0] lanes(
    input logic [DBW-1:0] k
  );
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < DBW; i++) begin
      m[i*8 +: 8] = {8{k[i]}};
    end
    return m;
  endfunction

  function automatic logic [DBW-1:0] top_keep(
    input logic [CW-1:0] n
  );
    logic [DBW-1:0] ones;
    ones = '1;
    return ~(ones >> n);
  endfunction

  function automatic logic [CW-1:0] popcnt(
    input logic [DBW-1:0] k
  );
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DBW; i++) begin
      c = c + CW'(k[i]);
    end
    return c;
  endfunction

  assign k_in     = popcnt(keep_in);
  assign s_cnt    = CW'(strip_q);
  assign tot      = res_cnt_q + k_in;
  assign din_m    = data_in & lanes(keep_in);
  assign merged   = res_data_q | (din_m >> {res_cnt_q, 3'b000});
  assign out_load = !vld_q || ready_out;

  assign ready_in    = (state_q == FIRST) ||
                       ((state_q == STREAM) && out_load);
  assign ready_strip = rst_n && (state_q == IDLE);

  assign valid_out = vld_q;
  assign data_out  = dat_q;
  assign keep_out  = kep_q;
  assign last_out  = lst_q;

  // Next state, residual repacking and output register loading
  always_comb begin
    state_d    = state_q;
    strip_d    = strip_q;
    res_data_d = res_data_q;
    res_cnt_d  = res_cnt_q;
    vld_d      = vld_q;
    dat_d      = dat_q;
    kep_d      = kep_q;
    lst_d      = lst_q;
    if (out_load) begin
      vld_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (valid_strip) begin
          strip_d = SW'(byte_strip_cnt) + SW'(1);
          state_d = FIRST;
        end
      end
      FIRST: begin
        if (valid_in) begin
          res_data_d = din_m << {strip_q, 3'b000};
          res_cnt_d  = (k_in > s_cnt) ? (k_in - s_cnt) : '0;
          if (!last_in) begin
            state_d = STREAM;
          end else if (k_in > s_cnt) begin
            state_d = FLUSH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      STREAM: begin
        if (valid_in && out_load) begin
          vld_d = 1'b1;
          dat_d = merged;
          unique case (1'b1)
            tot < DBW_C: begin
              kep_d      = top_keep(tot);
              lst_d      = 1'b1;
              res_data_d = '0;
              res_cnt_d  = '0;
              state_d    = IDLE;
            end
            last_in && (tot > DBW_C): begin
              kep_d      = '1;
              lst_d      = 1'b0;
              res_data_d = din_m << {DBW_C - res_cnt_q, 3'b000};
              res_cnt_d  = tot - DBW_C;
              state_d    = FLUSH;
            end
            last_in && (tot == DBW_C): begin
              kep_d      = '1;
              lst_d      = 1'b1;
              res_data_d = '0;
              res_cnt_d  = '0;
              state_d    = IDLE;
            end
            default: begin
              kep_d      = '1;
              lst_d      = 1'b0;
              res_data_d = din_m << {DBW_C - res_cnt_q, 3'b000};
              res_cnt_d  = tot - DBW_C;
            end
          endcase
        end
      end
      FLUSH: begin
        if (out_load) begin
          vld_d      = 1'b1;
          dat_d      = res_data_q;
          kep_d      = top_keep(res_cnt_q);
          lst_d      = 1'b1;
          res_data_d = '0;
          res_cnt_d  = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, residual and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      strip_q    <= '0;
      res_data_q <= '0;
      res_cnt_q  <= '0;
      vld_q      <= 1'b0;
      dat_q      <= '0;
      kep_q      <= '0;
      lst_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      strip_q    <= strip_d;
      res_data_q <= res_data_d;
      res_cnt_q  <= res_cnt_d;
      vld_q      <= vld_d;
      dat_q      <= dat_d;
      kep_q      <= kep_d;
      lst_q      <= lst_d;
    end
  end

`ifdef AXIS_STRIP_HEADER_CAPTURE_EN
  logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
  logic                  hdr_v_q, hdr_v_d;

  // Capture the upper S lanes of the first beat as it is accepted
  always_comb begin
    hdr_d   = hdr_q;
    hdr_v_d = 1'b0;
    if ((state_q == FIRST) && valid_in) begin
      hdr_d   = data_in & lanes(top_keep(s_cnt));
      hdr_v_d = 1'b1;
    end
  end

  // Header register and one-cycle valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q   <= '0;
      hdr_v_q <= 1'b0;
    end else begin
      hdr_q   <= hdr_d;
      hdr_v_q <= hdr_v_d;
    end
  end

  assign header_out   = hdr_q;
  assign header_valid = hdr_v_q;
`endif

endmodule
